// File: rtl/stage_decision.sv
// Per-stage verdict for the cascade classifier: accumulates signed weak-classifier
// votes, reads the stage threshold from ROM and emits continue/reject/detect.
module stage_decision #(
  parameter int W_VOTE    = 16,
  parameter int W_SUM     = 20,
  parameter int W_DATA    = 16,
  parameter int W_ADDR    = 16,
  parameter int STAGE_NUM = 25,
  parameter int W_STAGE   = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // vote stream: data = {last, vote}
  input  logic                 vote_valid,
  output logic                 vote_ready,
  input  logic [W_VOTE:0]      vote_data,
  // threshold ROM read address
  output logic                 thr_addr_valid,
  input  logic                 thr_addr_ready,
  output logic [W_ADDR-1:0]    thr_addr_data,
  // threshold ROM read data
  input  logic                 thr_data_valid,
  output logic                 thr_data_ready,
  input  logic [W_DATA-1:0]    thr_data_data,
  // verdict: data = {stage, code}
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [W_STAGE+1:0]   result_data
);

  localparam logic [1:0] CODE_CONT = 2'b00;
  localparam logic [1:0] CODE_REJ  = 2'b01;
  localparam logic [1:0] CODE_DET  = 2'b10;
  localparam logic [W_STAGE-1:0] STAGE_LAST = W_STAGE'(STAGE_NUM - 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'b00,
    RD_ADDR = 2'b01,
    RD_DATA = 2'b10,
    RESULT  = 2'b11
  } state_t;

  function automatic logic signed [W_SUM-1:0] sext_vote(input logic [W_VOTE-1:0] v);
    sext_vote = W_SUM'($signed(v));
  endfunction

  function automatic logic signed [W_SUM-1:0] sext_thr(input logic [W_DATA-1:0] t);
    sext_thr = W_SUM'($signed(t));
  endfunction

  state_t                state_r, state_nx_s;
  logic [W_SUM-1:0]      sum_r, sum_nx_s;
  logic [W_STAGE-1:0]    stage_r, stage_nx_s;
  logic [1:0]            code_r, code_nx_s;
  logic                  pass_s;

  logic                  vote_ready_r;
  logic                  thr_addr_valid_r;
  logic [W_ADDR-1:0]     thr_addr_data_r;
  logic                  thr_data_ready_r;
  logic                  result_valid_r;
  logic [W_STAGE+1:0]    result_data_r;

  assign vote_ready     = vote_ready_r;
  assign thr_addr_valid = thr_addr_valid_r;
  assign thr_addr_data  = thr_addr_data_r;
  assign thr_data_ready = thr_data_ready_r;
  assign result_valid   = result_valid_r;
  assign result_data    = result_data_r;

  // Next-state and datapath update for the four-phase stage sequence
  always_comb begin
    state_nx_s = state_r;
    sum_nx_s   = sum_r;
    stage_nx_s = stage_r;
    code_nx_s  = code_r;
    pass_s     = ($signed(sum_r) >= sext_thr(thr_data_data));
    case (state_r)
      ACCUM: begin
        if (vote_valid && vote_ready_r) begin
          sum_nx_s = sum_r + sext_vote(vote_data[W_VOTE-1:0]);
          if (vote_data[W_VOTE]) begin
            state_nx_s = RD_ADDR;
          end else begin
            state_nx_s = ACCUM;
          end
        end else begin
          state_nx_s = ACCUM;
        end
      end
      RD_ADDR: begin
        if (thr_addr_valid_r && thr_addr_ready) begin
          state_nx_s = RD_DATA;
        end else begin
          state_nx_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (thr_data_valid && thr_data_ready_r) begin
          state_nx_s = RESULT;
          if (!pass_s) begin
            code_nx_s = CODE_REJ;
          end else if (stage_r == STAGE_LAST) begin
            code_nx_s = CODE_DET;
          end else begin
            code_nx_s = CODE_CONT;
          end
        end else begin
          state_nx_s = RD_DATA;
        end
      end
      RESULT: begin
        if (result_valid_r && result_ready) begin
          state_nx_s = ACCUM;
          sum_nx_s   = {W_SUM{1'b0}};
          // Only a continue advances; reject or detect restarts the cascade
          if (code_r == CODE_CONT) begin
            stage_nx_s = stage_r + W_STAGE'(1);
          end else begin
            stage_nx_s = {W_STAGE{1'b0}};
          end
        end else begin
          state_nx_s = RESULT;
        end
      end
      default: begin
        state_nx_s = ACCUM;
      end
    endcase
  end

  // State, datapath and registered handshake outputs decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= ACCUM;
      sum_r            <= {W_SUM{1'b0}};
      stage_r          <= {W_STAGE{1'b0}};
      code_r           <= 2'b00;
      vote_ready_r     <= 1'b1;
      thr_addr_valid_r <= 1'b0;
      thr_addr_data_r  <= {W_ADDR{1'b0}};
      thr_data_ready_r <= 1'b0;
      result_valid_r   <= 1'b0;
      result_data_r    <= {(W_STAGE+2){1'b0}};
    end else begin
      state_r          <= state_nx_s;
      sum_r            <= sum_nx_s;
      stage_r          <= stage_nx_s;
      code_r           <= code_nx_s;
      vote_ready_r     <= (state_nx_s == ACCUM);
      thr_addr_valid_r <= (state_nx_s == RD_ADDR);
      thr_addr_data_r  <= (state_nx_s == RD_ADDR) ? W_ADDR'(stage_nx_s) : {W_ADDR{1'b0}};
      thr_data_ready_r <= (state_nx_s == RD_DATA);
      result_valid_r   <= (state_nx_s == RESULT);
      result_data_r    <= (state_nx_s == RESULT) ? {stage_nx_s, code_nx_s}
                                                 : {(W_STAGE+2){1'b0}};
    end
  end

endmodule

// File: doc/stage_decision.md
Name: stage_decision

Overview:
- Downstream consumer of the stage-threshold ROM read port in the cascade classifier datapath.
- Accumulates signed weak-classifier votes for the current stage and fetches that stage's threshold over the dti read-address/read-data pair.
- Compares the stage sum against the threshold, then emits a per-stage verdict: continue, reject or detect.
- Tracks the stage index for the window under evaluation.

Parameters:
- W_VOTE, 16, width of one signed weak-classifier vote.
- W_SUM, 20, width of the signed stage accumulator; must be ≥ W_VOTE and ≥ W_DATA.
- W_DATA, 16, width of the signed threshold word returned by the ROM.
- W_ADDR, 16, ROM address width.
- STAGE_NUM, 25, number of cascade stages; must be ≥ 1.
- W_STAGE, $clog2(STAGE_NUM), width of the stage index.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- vote_if  dti.consumer  W_VOTE+1  data = {last, vote}; last=1 marks the final vote of a stage.
- thr_addr_if  dti.producer  W_ADDR  threshold ROM read address; equals the zero-extended stage index.
- thr_data_if  dti.consumer  W_DATA  signed threshold returned by the ROM.
- result_if  dti.producer  W_STAGE+2  data = {stage, code}; code 2'b00 = continue, 2'b01 = reject, 2'b10 = detect.

Behaviour:
- Handshake rules (all dti ports):
  - A transfer occurs on a rising edge with valid && ready.
  - The producer holds data and valid stable until ready. valid never depends combinationally on ready.
- Reset (rst=0, asynchronous):
  - state=ACCUM, sum=0, stage=0.
  - Registered valid outputs (thr_addr_if.valid, result_if.valid) = 0; their data outputs = 0.
  - Consumer ready outputs follow the FSM state decode: vote_if.ready=1 (state ACCUM), thr_data_if.ready=0.
  - A reset mid-operation abandons any partial sum, outstanding read or pending result. No result is emitted for the abandoned window.
- FSM states:
  - ACCUM:
    - vote_if.ready=1. On each transfer, sum <= sum + sign_extend(vote).
    - If last=1, the same edge stores the final sum and moves to RD_ADDR.
  - RD_ADDR:
    - thr_addr_if.valid=1, data=stage. vote_if.ready=0.
    - On transfer -> RD_DATA.
  - RD_DATA:
    - thr_data_if.ready=1.
    - On transfer, register pass = (sum >= sign_extend(threshold)), using a signed W_SUM comparison -> RESULT.
  - RESULT:
    - result_if.valid=1, data={stage, code}.
    - code: !pass -> reject; pass && stage==STAGE_NUM-1 -> detect; else continue.
    - On transfer: sum <= 0. stage <= stage+1 for continue, 0 for reject or detect. State -> ACCUM.
- Arithmetic:
  - Accumulation wraps in two's complement at W_SUM bits. There is no saturation; sizing W_SUM to avoid overflow is the integrator's job.
  - Threshold equal to the sum counts as pass.
- Latency:
  - From the last vote transfer to thr_addr_if.valid: 1 cycle.
  - From the thr_data transfer to result_if.valid: 1 cycle.
  - Minimum 4 cycles per stage beyond the vote stream when the ROM answers in 1 cycle and result_if.ready=1.
- Boundary conditions:
  - A single-vote stage (first vote has last=1) is legal.
  - Backpressure on result_if stalls the block in RESULT. vote_if.ready stays 0 and no votes are lost.
  - thr_data_if.valid arriving outside RD_DATA is not accepted (ready=0).
  - STAGE_NUM=1: every pass is a detect.

Test Plan:
- Stage 0, votes {+100, -30, +50(last)}, threshold 100 -> addr 0 issued; result {stage=0, continue}; stage becomes 1; sum cleared.
- Votes {+40, +59(last)}, threshold 100 -> result reject; stage returns to 0. Repeat with threshold 99 -> continue (equality passes).
- Full cascade, STAGE_NUM=3, all stages pass -> results continue(0), continue(1), detect(2); then stage=0 and the next window addresses ROM 0.
- Negative arithmetic: votes {-500, +200(last)}, threshold -300 (16'hFED4) -> pass; threshold -299 -> reject.
- Backpressure: hold result_if.ready=0 for 10 cycles while vote_if.valid=1 -> vote_if.ready=0 throughout; result data stable; no vote accepted until the result transfers. Randomised ROM latency of 1-5 cycles gives the same verdicts.
- Assert rst in RD_DATA, then release -> outputs at reset values; the next window starts at stage 0 with sum 0; no stale result appears.
